// File: rtl/ps2_pkg.sv
// Shared constants and types for the PS/2 keyboard receive path.
package ps2_pkg;

    // Scan-code prefixes folded into flags rather than reported as keys
    localparam logic [7:0] PS2_PFX_EXT = 8'hE0;
    localparam logic [7:0] PS2_PFX_BRK = 8'hF0;

    // Device-to-host frame: start, 8 data, parity, stop
    localparam int unsigned FRAME_BITS = 11;
    localparam int unsigned DATA_BITS  = FRAME_BITS - 3;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } frame_state_e;

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: synchronises the raw lines, finds PS2_CLK falls,
// deframes 11-bit frames and flags parity, stop-bit and timeout errors.
module ps2_frame_rx
    import ps2_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 50000,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       ps2_clk_i,
    input  logic       ps2_dat_i,
    output logic       byte_vld_o,
    output logic [7:0] byte_o,
    output logic       err_o
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYC + 1);

    logic [SYNC_STAGES-1:0] clk_sync_q;
    logic [SYNC_STAGES-1:0] dat_sync_q;
    logic                   clk_prev_q;
    logic                   clk_cur;
    logic                   dat_cur;
    logic                   fall;

    frame_state_e state_q, state_d;
    logic [2:0]   bitcnt_q, bitcnt_d;
    logic [7:0]   shift_q, shift_d;
    logic         par_q, par_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Synchronisers reset high to match an idle bus; prev-clock register for edge detect
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            clk_sync_q <= '1;
            dat_sync_q <= '1;
            clk_prev_q <= 1'b1;
        end else begin
            clk_sync_q <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk_i};
            dat_sync_q <= {dat_sync_q[SYNC_STAGES-2:0], ps2_dat_i};
            clk_prev_q <= clk_sync_q[SYNC_STAGES-1];
        end
    end

    assign clk_cur = clk_sync_q[SYNC_STAGES-1];
    assign dat_cur = dat_sync_q[SYNC_STAGES-1];
    assign fall    = clk_prev_q & ~clk_cur;

    // Frame state, shift register, parity capture and timeout counter
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= IDLE;
            bitcnt_q <= '0;
            shift_q  <= '0;
            par_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            bitcnt_q <= bitcnt_d;
            shift_q  <= shift_d;
            par_q    <= par_d;
            cnt_q    <= cnt_d;
        end
    end

    // Next-state: deframe on each fall; a fall in the terminal-count cycle beats the timeout
    always_comb begin
        state_d    = state_q;
        bitcnt_d   = bitcnt_q;
        shift_d    = shift_q;
        par_d      = par_q;
        cnt_d      = cnt_q;
        byte_vld_o = 1'b0;
        err_o      = 1'b0;

        if (fall) begin
            cnt_d = '0;
            unique case (state_q)
                IDLE: begin
                    if (!dat_cur) begin
                        state_d  = DATA;
                        bitcnt_d = '0;
                    end
                end
                DATA: begin
                    shift_d  = {dat_cur, shift_q[7:1]};
                    bitcnt_d = bitcnt_q + 3'd1;
                    if (bitcnt_q == 3'(DATA_BITS - 1)) state_d = PARITY;
                end
                PARITY: begin
                    par_d   = dat_cur;
                    state_d = STOP;
                end
                STOP: begin
                    state_d = IDLE;
                    if (dat_cur && (^shift_q ^ par_q)) byte_vld_o = 1'b1;
                    else                               err_o      = 1'b1;
                end
                default: state_d = IDLE;
            endcase
        end else if (state_q == IDLE) begin
            cnt_d = '0;
        end else if (cnt_q == CW'(TIMEOUT_CYC)) begin
            cnt_d   = '0;
            state_d = IDLE;
            err_o   = 1'b1;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    assign byte_o = shift_q;

endmodule

// File: rtl/ps2_keydec_funcmod.sv
// PS/2 keyboard decoder top: folds E0/F0 prefixes into flags and registers
// one key event per non-prefix byte, plus a one-cycle error strobe.
module ps2_keydec_funcmod
    import ps2_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 50000,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       CLOCK,
    input  logic       RST_n,
    input  logic       PS2_CLK,
    input  logic       PS2_DAT,
    output logic [7:0] oData,
    output logic       oTrig,
    output logic       oExt,
    output logic       oBrk,
    output logic       oErr
);

    logic       rx_vld;
    logic [7:0] rx_byte;
    logic       rx_err;

    logic [7:0] data_q, data_d;
    logic       ext_q, ext_d;
    logic       brk_q, brk_d;
    logic       trig_q, trig_d;
    logic       err_q, err_d;
    logic       pfx_ext_q, pfx_ext_d;
    logic       pfx_brk_q, pfx_brk_d;

    ps2_frame_rx #(
        .TIMEOUT_CYC(TIMEOUT_CYC),
        .SYNC_STAGES(SYNC_STAGES)
    ) u_rx (
        .clk_i     (CLOCK),
        .rst_n_i   (RST_n),
        .ps2_clk_i (PS2_CLK),
        .ps2_dat_i (PS2_DAT),
        .byte_vld_o(rx_vld),
        .byte_o    (rx_byte),
        .err_o     (rx_err)
    );

    // Output and prefix-flag registers
    always_ff @(posedge CLOCK or negedge RST_n) begin
        if (!RST_n) begin
            data_q    <= 8'h00;
            ext_q     <= 1'b0;
            brk_q     <= 1'b0;
            trig_q    <= 1'b0;
            err_q     <= 1'b0;
            pfx_ext_q <= 1'b0;
            pfx_brk_q <= 1'b0;
        end else begin
            data_q    <= data_d;
            ext_q     <= ext_d;
            brk_q     <= brk_d;
            trig_q    <= trig_d;
            err_q     <= err_d;
            pfx_ext_q <= pfx_ext_d;
            pfx_brk_q <= pfx_brk_d;
        end
    end

    // Prefixes only set flags; any other byte publishes an event; errors drop pending prefixes
    always_comb begin
        data_d    = data_q;
        ext_d     = ext_q;
        brk_d     = brk_q;
        trig_d    = 1'b0;
        err_d     = 1'b0;
        pfx_ext_d = pfx_ext_q;
        pfx_brk_d = pfx_brk_q;

        if (rx_vld) begin
            if (rx_byte == PS2_PFX_EXT) begin
                pfx_ext_d = 1'b1;
            end else if (rx_byte == PS2_PFX_BRK) begin
                pfx_brk_d = 1'b1;
            end else begin
                data_d    = rx_byte;
                ext_d     = pfx_ext_q;
                brk_d     = pfx_brk_q;
                trig_d    = 1'b1;
                pfx_ext_d = 1'b0;
                pfx_brk_d = 1'b0;
            end
        end else if (rx_err) begin
            err_d     = 1'b1;
            pfx_ext_d = 1'b0;
            pfx_brk_d = 1'b0;
        end
    end

    assign oData = data_q;
    assign oExt  = ext_q;
    assign oBrk  = brk_q;
    assign oTrig = trig_q;
    assign oErr  = err_q;

endmodule

// File: tb/tb_ps2_keydec_funcmod.sv
// Scoreboard bench for ps2_keydec_funcmod: stimulus pushes expected events,
// a monitor pops and compares on every oTrig/oErr strobe.
`timescale 1ns/1ps
module tb_ps2_keydec_funcmod;

    localparam int unsigned TMO  = 200;  // cycles
    localparam int unsigned HALF = 40;   // PS/2 half period in cycles (12.5 kHz at 1 MHz)

    logic       CLOCK = 1'b0;
    logic       RST_n = 1'b0;
    logic       PS2_CLK = 1'b1;
    logic       PS2_DAT = 1'b1;
    logic [7:0] oData;
    logic       oTrig, oExt, oBrk, oErr;

    typedef struct {
        bit         is_err;
        logic [7:0] d;
        logic       ext;
        logic       brk;
    } ev_t;

    ev_t exp_q[$];
    int  n_checks = 0;
    int  n_fail   = 0;

    ps2_keydec_funcmod #(.TIMEOUT_CYC(TMO), .SYNC_STAGES(2)) dut (
        .CLOCK  (CLOCK),
        .RST_n  (RST_n),
        .PS2_CLK(PS2_CLK),
        .PS2_DAT(PS2_DAT),
        .oData  (oData),
        .oTrig  (oTrig),
        .oExt   (oExt),
        .oBrk   (oBrk),
        .oErr   (oErr)
    );

    always #500 CLOCK = ~CLOCK;  // 1 MHz

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge CLOCK);
        #1;
    endtask

    // Drive the first nedges bits of a frame; device changes data while PS2_CLK is high
    task automatic send_frame(input logic [7:0] b, input bit flip_par, input logic stop, input int nedges);
        logic [10:0] fr;
        logic        par;
        par = (~^b) ^ flip_par;
        fr  = {stop, par, b, 1'b0};
        for (int i = 0; i < nedges; i++) begin
            PS2_DAT = fr[i];
            wait_cyc(HALF);
            PS2_CLK = 1'b0;
            wait_cyc(HALF);
            PS2_CLK = 1'b1;
        end
        wait_cyc(HALF);
        PS2_DAT = 1'b1;
        wait_cyc(HALF);
    endtask

    task automatic push(input bit is_err, input logic [7:0] d, input logic ext, input logic brk);
        ev_t e;
        e.is_err = is_err;
        e.d      = d;
        e.ext    = ext;
        e.brk    = brk;
        exp_q.push_back(e);
    endtask

    // Monitor: every strobe must match the head of the scoreboard
    always @(negedge CLOCK) begin
        if (RST_n && (oTrig || oErr)) begin
            check("trig_err_exclusive", {31'd0, oTrig & oErr}, 32'd0);
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_strobe: trig=%0b err=%0b data=%0h at %0t", oTrig, oErr, oData, $time);
            end else begin
                ev_t e;
                e = exp_q.pop_front();
                check("strobe_kind_err", {31'd0, oErr}, {31'd0, e.is_err});
                check("oData", {24'd0, oData}, {24'd0, e.d});
                check("oExt", {31'd0, oExt}, {31'd0, e.ext});
                check("oBrk", {31'd0, oBrk}, {31'd0, e.brk});
            end
        end
    end

    initial begin
        // Reset state
        wait_cyc(5);
        check("rst_oData", {24'd0, oData}, 32'h0);
        check("rst_oTrig", {31'd0, oTrig}, 32'h0);
        check("rst_oExt",  {31'd0, oExt},  32'h0);
        check("rst_oBrk",  {31'd0, oBrk},  32'h0);
        check("rst_oErr",  {31'd0, oErr},  32'h0);
        RST_n = 1'b1;
        wait_cyc(10);

        // Plain make code
        push(0, 8'h1C, 0, 0);
        send_frame(8'h1C, 0, 1'b1, 11);

        // Break prefix, then a bare code clears it
        send_frame(8'hF0, 0, 1'b1, 11);
        push(0, 8'h1C, 0, 1);
        send_frame(8'h1C, 0, 1'b1, 11);
        push(0, 8'h1C, 0, 0);
        send_frame(8'h1C, 0, 1'b1, 11);

        // Extended release
        send_frame(8'hE0, 0, 1'b1, 11);
        send_frame(8'hF0, 0, 1'b1, 11);
        push(0, 8'h75, 1, 1);
        send_frame(8'h75, 0, 1'b1, 11);

        // Parity error, then stop-bit error; outputs hold previous event
        push(1, 8'h75, 1, 1);
        send_frame(8'h1C, 1, 1'b1, 11);
        push(1, 8'h75, 1, 1);
        send_frame(8'h1C, 0, 1'b0, 11);

        // Timeout mid-frame after E0 drops the prefix
        send_frame(8'hE0, 0, 1'b1, 11);
        push(1, 8'h75, 1, 1);
        send_frame(8'h3C, 0, 1'b1, 5);
        wait_cyc(TMO + 100);
        push(0, 8'h29, 0, 0);
        send_frame(8'h29, 0, 1'b1, 11);

        // Reset mid-frame after bit 5, then a clean frame
        send_frame(8'hE0, 0, 1'b1, 11);
        send_frame(8'h33, 0, 1'b1, 6);
        RST_n = 1'b0;
        wait_cyc(5);
        check("midrst_oData", {24'd0, oData}, 32'h0);
        check("midrst_oTrig", {31'd0, oTrig}, 32'h0);
        check("midrst_oExt",  {31'd0, oExt},  32'h0);
        check("midrst_oBrk",  {31'd0, oBrk},  32'h0);
        check("midrst_oErr",  {31'd0, oErr},  32'h0);
        RST_n = 1'b1;
        wait_cyc(10);
        push(0, 8'h5A, 0, 0);
        send_frame(8'h5A, 0, 1'b1, 11);

        wait_cyc(50);
        check("scoreboard_drained", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ps2_keydec_funcmod.md
# ps2_keydec_funcmod

PS/2 keyboard receive front end: synchronises the raw PS2_CLK/PS2_DAT lines, deframes 11-bit device-to-host frames, checks parity, stop bit and inter-edge timeout, and folds the E0 (extended) and F0 (break) prefixes into flags on a single key event. It sits directly upstream of the display and test logic. oData/oTrig keep the same meaning the rest of the design already consumes: a byte plus a one-cycle strobe.

## Interface
- TIMEOUT_CYC, 50000, max CLOCK cycles between PS2_CLK falling edges inside a frame (1 ms at 50 MHz); must be ≥ 2
- SYNC_STAGES, 2, synchroniser depth for PS2_CLK and PS2_DAT; must be ≥ 2

- CLOCK  in  1  system clock; the only clock
- RST_n  in  1  asynchronous, active-low reset
- PS2_CLK  in  1  raw PS/2 clock from the device, asynchronous
- PS2_DAT  in  1  raw PS/2 data from the device, asynchronous
- oData  out  8  last completed key code, prefixes stripped
- oTrig  out  1  one-cycle strobe; oData, oExt and oBrk are valid in that cycle
- oExt  out  1  event was preceded by E0
- oBrk  out  1  event was preceded by F0 (key release)
- oErr  out  1  one-cycle strobe on a parity, stop-bit or timeout error

## Operation
- Both inputs pass through SYNC_STAGES flops, and one extra register holds the previous synced clock. A falling edge is prev=1, cur=0. Data is sampled from the synced PS2_DAT in the edge cycle.
- Frame FSM states and transitions:
  - IDLE: on an edge with data=0 (start bit), go to DATA with bit count 0. An edge with data=1 is ignored, and the FSM stays in IDLE.
  - DATA: shift in 8 bits, LSB first; after the 8th bit go to PARITY.
  - PARITY: capture the bit, then go to STOP.
  - STOP: on the edge, the frame is good when the stop bit is 1 and the XOR of the 8 data bits and the parity bit is 1 (odd parity). Return to IDLE in either case.
- Decoder, acting on each good byte:
  - E0 sets the ext flag; F0 sets the brk flag. Neither raises oTrig.
  - Any other byte, including E1, AA and FA, latches oData=byte, oExt=ext flag and oBrk=brk flag, pulses oTrig, then clears both flags.
- Bad frame (parity or stop-bit error):
  - Pulse oErr for one cycle and clear both prefix flags.
  - oData, oExt and oBrk keep their previous values.
- Timeout:
  - The counter resets on every edge and counts only while the FSM is not in IDLE.
  - On reaching TIMEOUT_CYC: force IDLE, pulse oErr, clear the prefix flags.
  - An edge arriving in the same cycle as the terminal count wins: no timeout is raised.
- oErr and oTrig are never asserted in the same cycle.

## Timing
- Reset values: oData=8'h00, oTrig=0, oExt=0, oBrk=0, oErr=0, FSM=IDLE, prefix flags=0, timeout counter=0, sync flops=1 (idle-high bus).
- Input latency: a PS2_CLK fall appears as an edge SYNC_STAGES+1 cycles after it reaches the pin.
- Output latency: oTrig or oErr (frame errors) rises exactly one cycle after the stop-bit edge cycle.
  - oTrig is high for exactly one cycle.
  - oData, oExt and oBrk change only in the oTrig cycle and then hold until the next oTrig.
- A timeout oErr fires one cycle after the counter reaches TIMEOUT_CYC.
- Reset mid-frame discards the partial frame and all prefixes; no strobe is emitted.
- PS2_CLK rates of 10–16.7 kHz must work at any CLOCK ≥ 1 MHz. No host-to-device transmit; both lines are input-only.

## Structure
- Shared package ps2_pkg holds:
  - PS2_PFX_EXT = 8'hE0 and PS2_PFX_BRK = 8'hF0
  - the frame-state enum (IDLE, DATA, PARITY, STOP)
  - the frame length constant (11 bits)
- One sub-module, ps2_frame_rx, contains the synchroniser, edge detector, frame FSM, parity/stop check and timeout counter. It outputs a good-byte strobe, the byte, and an error strobe.
- The top level contains the prefix flags and output registers.

## Test plan
- Frame 0x1C, parity 0, stop 1, at 12.5 kHz → one oTrig; oData=8'h1C, oExt=0, oBrk=0; oErr stays 0.
- Frames F0, 1C → no strobe after F0; one oTrig after 1C with oData=8'h1C, oBrk=1, oExt=0. A following bare 0x1C gives oBrk=0.
- Frames E0, F0, 75 → exactly one oTrig, with oData=8'h75, oExt=1, oBrk=1.
- Frame 0x1C with parity bit flipped to 1 → one oErr pulse, no oTrig, oData unchanged. Repeat with the stop bit forced to 0 → same response.
- After E0, drive 4 bits of the next frame, then hold PS2_CLK high for more than TIMEOUT_CYC → one oErr pulse. A following clean 0x29 gives oData=8'h29 with oExt=0, which shows the prefix was cleared.
- Assert RST_n low after bit 5 of a frame, release it, then send 0x5A → all outputs at reset values during reset, no strobe from the partial frame, then oTrig with oData=8'h5A.
